// File: rtl/uart_pkg.sv
// Shared encodings for the buffered UART transmitter: FSM state codes and line constants.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;
   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Word-push handshake between the system datapath and the UART transmit buffer.
interface uart_tx_buffered_if #(
   parameter int unsigned DATA_WIDTH = 8
) ();

   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  DATA_READY;

   modport master (
      output P_DATA,
      output DATA_VALID,
      input  DATA_READY
   );

   modport slave (
      input  P_DATA,
      input  DATA_VALID,
      output DATA_READY
   );

endinterface

// File: rtl/uart_tx_fifo_buf.sv
// Synchronous word FIFO with fall-through read data and an occupancy count.
module uart_tx_fifo_buf #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        push_i,
   input  logic                        pop_i,
   input  logic [DATA_WIDTH-1:0]       wdata_i,
   output logic [DATA_WIDTH-1:0]       rdata_o,
   output logic [$clog2(FIFO_DEPTH):0] count_o
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]       count_q, count_d;

   // Depth is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      wr_ptr_d = push_i ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop_i  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed framer with programmable bit period, parity and stop bits.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic                        CLK,
   input  logic                        RST,
   uart_tx_buffered_if.slave           in_if,
   input  logic                        PAR_EN,
   input  logic                        PAR_TYPE,
   input  logic                        STOP2,
   input  logic [PRESCALE_W-1:0]       PRESCALE,
   output logic                        S_DATA,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);

   localparam logic [2:0] StIdle   = IDLE;
   localparam logic [2:0] StStart  = START;
   localparam logic [2:0] StData   = DATA;
   localparam logic [2:0] StParity = PARITY;
   localparam logic [2:0] StStop   = STOP;

   logic [2:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
   logic [BitW-1:0]       bcnt_q, bcnt_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;
   logic                  stop2_q, stop2_d;
   logic                  s_data_q, busy_q;
   logic                  line;
   logic                  bit_end;
   logic                  push, pop;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic [CntW-1:0]       count;

   assign in_if.DATA_READY = (count != CntW'(FIFO_DEPTH));
   assign push             = in_if.DATA_VALID & in_if.DATA_READY;

   uart_tx_fifo_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (in_if.P_DATA),
      .rdata_o (fifo_rdata),
      .count_o (count)
   );

   assign bit_end = (pcnt_q == presc_q - PRESCALE_W'(1));

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      presc_d   = presc_q;
      pcnt_d    = pcnt_q;
      bcnt_d    = bcnt_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      stop2_d   = stop2_q;
      pop       = 1'b0;
      line      = LINE_IDLE;

      if (state_q != StIdle) begin
         pcnt_d = bit_end ? '0 : pcnt_q + PRESCALE_W'(1);
      end

      case (state_q)
         StIdle: begin
            if (count != '0) pop = 1'b1;
         end
         StStart: begin
            line = 1'b0;
            if (bit_end) state_d = StData;
         end
         StData: begin
            line = shift_q[0];
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bcnt_q == BitW'(DATA_WIDTH - 1)) begin
                  bcnt_d  = '0;
                  state_d = par_en_q ? StParity : StStop;
               end else begin
                  bcnt_d = bcnt_q + BitW'(1);
               end
            end
         end
         StParity: begin
            line = par_bit_q;
            if (bit_end) state_d = StStop;
         end
         StStop: begin
            // bcnt_q marks the first of two stop bits when STOP2 was latched.
            if (bit_end) begin
               if (stop2_q && bcnt_q == '0) begin
                  bcnt_d = BitW'(1);
               end else if (count != '0) begin
                  pop = 1'b1;
               end else begin
                  bcnt_d  = '0;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Frame format is captured here so later config changes only hit later frames.
      if (pop) begin
         shift_d   = fifo_rdata;
         par_en_d  = PAR_EN;
         stop2_d   = STOP2;
         presc_d   = (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
         par_bit_d = (^fifo_rdata) ^ (PAR_TYPE == PAR_ODD);
         pcnt_d    = '0;
         bcnt_d    = '0;
         state_d   = StStart;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         presc_q   <= PRESCALE_W'(1);
         pcnt_q    <= '0;
         bcnt_q    <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
         s_data_q  <= LINE_IDLE;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         presc_q   <= presc_d;
         pcnt_q    <= pcnt_d;
         bcnt_q    <= bcnt_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         stop2_q   <= stop2_d;
         s_data_q  <= line;
         busy_q    <= (state_q != StIdle);
      end
   end

   assign S_DATA     = s_data_q;
   assign busy       = busy_q;
   assign fifo_count = count;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: framing, parity, stop bits, buffering and reset abort.
module tb_uart_tx_buffered;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PW    = 16;

   logic          CLK      = 1'b0;
   logic          RST      = 1'b0;
   logic          PAR_EN   = 1'b0;
   logic          PAR_TYPE = 1'b0;
   logic          STOP2    = 1'b0;
   logic [PW-1:0] PRESCALE = 16'd1;
   logic          S_DATA;
   logic          busy;
   logic [2:0]    fifo_count;

   int checks   = 0;
   int failures = 0;

   uart_tx_buffered_if #(.DATA_WIDTH(DW)) bus ();

   uart_tx_buffered #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .PRESCALE_W (PW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .in_if      (bus),
      .PAR_EN     (PAR_EN),
      .PAR_TYPE   (PAR_TYPE),
      .STOP2      (STOP2),
      .PRESCALE   (PRESCALE),
      .S_DATA     (S_DATA),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 CLK = ~CLK;

   // Returns 1 ns after the accepting clock edge.
   task automatic push_word(input logic [DW-1:0] d);
      int n = 0;
      @(negedge CLK);
      bus.P_DATA     = d;
      bus.DATA_VALID = 1'b1;
      while (!bus.DATA_READY && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 2000) begin
         checks++;
         failures++;
         $display("FAIL push_timeout ready=%b required 1", bus.DATA_READY);
      end
      @(posedge CLK);
      #1 bus.DATA_VALID = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         checks++;
         if ({S_DATA, busy, bus.DATA_READY, fifo_count} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL reset_hold got S_DATA=%b busy=%b ready=%b count=%0d required 1 0 1 0",
                     S_DATA, busy, bus.DATA_READY, fifo_count);
         end
      end
      RST = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge CLK);
         checks++;
         if ({S_DATA, busy, bus.DATA_READY, fifo_count} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d got S_DATA=%b busy=%b ready=%b count=%0d required 1 0 1 0",
                     c, S_DATA, busy, bus.DATA_READY, fifo_count);
         end
      end
   endtask

   task automatic test_single_frame();
      string seq = "01010010101";
      logic  exp_s, exp_b;
      PRESCALE = 16'd4; PAR_EN = 1'b1; PAR_TYPE = 1'b0; STOP2 = 1'b0;
      push_word(8'hA5);
      for (int c = 0; c < 2 + 44; c++) begin
         @(negedge CLK);
         exp_s = (c < 2) ? 1'b1 : (seq[(c - 2) / 4] == "1");
         exp_b = (c >= 2);
         checks++;
         if ({S_DATA, busy} !== {exp_s, exp_b}) begin
            failures++;
            $display("FAIL single_frame cyc=%0d got S_DATA=%b busy=%b required %b %b",
                     c, S_DATA, busy, exp_s, exp_b);
         end
      end
      @(negedge CLK);
      checks++;
      if ({S_DATA, busy} !== 2'b10) begin
         failures++;
         $display("FAIL single_frame_end got S_DATA=%b busy=%b required 1 0", S_DATA, busy);
      end
   endtask

   task automatic test_odd_stop2();
      string seq = "011100000011";
      logic  exp_s, exp_b;
      PRESCALE = 16'd1; PAR_EN = 1'b1; PAR_TYPE = 1'b1; STOP2 = 1'b1;
      push_word(8'h07);
      for (int c = 0; c < 2 + 12; c++) begin
         @(negedge CLK);
         exp_s = (c < 2) ? 1'b1 : (seq[c - 2] == "1");
         exp_b = (c >= 2);
         checks++;
         if ({S_DATA, busy} !== {exp_s, exp_b}) begin
            failures++;
            $display("FAIL odd_stop2 cyc=%0d got S_DATA=%b busy=%b required %b %b",
                     c, S_DATA, busy, exp_s, exp_b);
         end
      end
      @(negedge CLK);
      checks++;
      if ({S_DATA, busy} !== 2'b10) begin
         failures++;
         $display("FAIL odd_stop2_end got S_DATA=%b busy=%b required 1 0", S_DATA, busy);
      end
   endtask

   task automatic test_config_change();
      string seq1 = "00011110001";
      string seq2 = "0100000011";
      logic  exp_s, exp_b;
      PRESCALE = 16'd2; PAR_EN = 1'b1; PAR_TYPE = 1'b0; STOP2 = 1'b0;
      push_word(8'h3C);
      for (int c = 0; c < 2 + 22; c++) begin
         @(negedge CLK);
         if (c == 8) begin
            PAR_EN   = 1'b0;
            PRESCALE = 16'd0;
         end
         exp_s = (c < 2) ? 1'b1 : (seq1[(c - 2) / 2] == "1");
         exp_b = (c >= 2);
         checks++;
         if ({S_DATA, busy} !== {exp_s, exp_b}) begin
            failures++;
            $display("FAIL cfg_latched cyc=%0d got S_DATA=%b busy=%b required %b %b",
                     c, S_DATA, busy, exp_s, exp_b);
         end
      end
      @(negedge CLK);
      checks++;
      if ({S_DATA, busy} !== 2'b10) begin
         failures++;
         $display("FAIL cfg_latched_end got S_DATA=%b busy=%b required 1 0", S_DATA, busy);
      end
      push_word(8'h81);
      for (int c = 0; c < 2 + 10; c++) begin
         @(negedge CLK);
         exp_s = (c < 2) ? 1'b1 : (seq2[c - 2] == "1");
         exp_b = (c >= 2);
         checks++;
         if ({S_DATA, busy} !== {exp_s, exp_b}) begin
            failures++;
            $display("FAIL prescale_zero cyc=%0d got S_DATA=%b busy=%b required %b %b",
                     c, S_DATA, busy, exp_s, exp_b);
         end
      end
      @(negedge CLK);
      checks++;
      if ({S_DATA, busy} !== 2'b10) begin
         failures++;
         $display("FAIL prescale_zero_end got S_DATA=%b busy=%b required 1 0", S_DATA, busy);
      end
   endtask

   // Six words with DATA_VALID held high; a small frame-timing model tracks the expected
   // occupancy, line value and busy flag (PRESCALE=2, no parity, one stop bit: 20 cycles).
   task automatic test_back_to_back();
      logic [DW-1:0] words [6] = '{8'h11, 8'h22, 8'h96, 8'h0F, 8'hF0, 8'h5A};
      logic [DW-1:0] cur = '0;
      int   cnt = 0, sent = 0, popped = 0, ph = 0, b;
      logic idle = 1'b1, exp_s = 1'b1, exp_b = 1'b0, push, pop;
      PRESCALE = 16'd2; PAR_EN = 1'b0; PAR_TYPE = 1'b0; STOP2 = 1'b0;
      for (int c = 0; c < 140; c++) begin
         @(negedge CLK);
         checks++;
         if ({S_DATA, busy, bus.DATA_READY, fifo_count} !== {exp_s, exp_b, (cnt != 4), 3'(cnt)}) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d got S_DATA=%b busy=%b ready=%b count=%0d required %b %b %b %0d",
                     c, S_DATA, busy, bus.DATA_READY, fifo_count, exp_s, exp_b, (cnt != 4), cnt);
         end
         if (idle) begin
            exp_s = 1'b1;
         end else begin
            b     = ph / 2;
            exp_s = (b == 0) ? 1'b0 : (b <= 8) ? cur[b - 1] : 1'b1;
         end
         exp_b          = !idle;
         bus.DATA_VALID = (sent < 6);
         if (sent < 6) bus.P_DATA = words[sent];
         push = (sent < 6) && (cnt != 4);
         pop  = 1'b0;
         if (idle) begin
            if (cnt != 0) begin
               pop  = 1'b1;
               idle = 1'b0;
               ph   = 0;
            end
         end else if (ph == 19) begin
            if (cnt != 0) begin
               pop = 1'b1;
               ph  = 0;
            end else begin
               idle = 1'b1;
            end
         end else begin
            ph++;
         end
         if (pop) begin
            cur = words[popped];
            popped++;
         end
         if (push) sent++;
         cnt = cnt + int'(push) - int'(pop);
      end
      bus.DATA_VALID = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      PRESCALE = 16'd4; PAR_EN = 1'b0; PAR_TYPE = 1'b0; STOP2 = 1'b0;
      push_word(8'h00);
      push_word(8'h00);
      repeat (14) @(negedge CLK);
      checks++;
      if ({S_DATA, busy, fifo_count} !== {1'b0, 1'b1, 3'd1}) begin
         failures++;
         $display("FAIL mid_frame_pre got S_DATA=%b busy=%b count=%0d required 0 1 1",
                  S_DATA, busy, fifo_count);
      end
      #1 RST = 1'b0;
      #1;
      checks++;
      if ({S_DATA, busy, bus.DATA_READY, fifo_count} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
         failures++;
         $display("FAIL mid_frame_async got S_DATA=%b busy=%b ready=%b count=%0d required 1 0 1 0",
                  S_DATA, busy, bus.DATA_READY, fifo_count);
      end
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge CLK);
         checks++;
         if ({S_DATA, busy, fifo_count} !== {1'b1, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL mid_frame_after cyc=%0d got S_DATA=%b busy=%b count=%0d required 1 0 0",
                     c, S_DATA, busy, fifo_count);
         end
      end
   endtask

   initial begin
      bus.P_DATA     = '0;
      bus.DATA_VALID = 1'b0;
      test_reset();
      test_single_frame();
      test_odd_stop2();
      test_config_change();
      test_back_to_back();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
